// File: rtl/seq_detect_tick.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_tick
// Description : Serial pattern detector with built-in slow-tick divider.
//               Samples x once per tick, compares the last PAT_W samples
//               against PATTERN, raises z for one tick period per match and
//               keeps a saturating match count.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_tick #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
    parameter int                 DIV     = 50000000,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         x,
    output logic                         tick,
    output logic                         z,
    output logic [PAT_W-1:0]             hist,
    output logic [$clog2(PAT_W+1)-1:0]   fill,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat
);

    localparam int                  c_FILL_W    = $clog2(PAT_W + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PAT_W);

    logic                r_tick;
    logic                r_z;
    logic [PAT_W-1:0]    r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sat;

    logic [PAT_W-1:0]    w_hist_next;
    logic [c_FILL_W-1:0] w_fill_next;
    logic [c_FILL_W-1:0] w_fill_load;
    logic                w_match;
    logic [CNT_W-1:0]    w_cnt_next;

    generate
        if (DIV <= 1) begin : g_div_single
            // Every cycle is a sample point; tick only drops for the cycle after a reset edge.
            always_ff @(posedge clk) begin
                if (clr) begin
                    r_tick <= 1'b0;
                end else begin
                    r_tick <= 1'b1;
                end
            end
        end else begin : g_div_count
            localparam int                 c_DIV_W    = $clog2(DIV);
            localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);

            logic [c_DIV_W-1:0] r_div;
            logic [c_DIV_W-1:0] w_div_next;

            // Next divider value, wrapping from DIV-1 back to zero.
            always_comb begin
                w_div_next = r_div + c_DIV_W'(1);
                if (r_div == c_DIV_LAST) begin
                    w_div_next = '0;
                end
            end

            // Divider register; tick is registered from the next count so it is high exactly while r_div==DIV-1.
            always_ff @(posedge clk) begin
                if (clr) begin
                    r_div  <= '0;
                    r_tick <= 1'b0;
                end else begin
                    r_div  <= w_div_next;
                    r_tick <= (w_div_next == c_DIV_LAST);
                end
            end
        end
    endgenerate

    // Shift/fill/match evaluation on post-shift values; nothing moves outside tick cycles.
    always_comb begin
        w_hist_next = r_hist;
        w_fill_next = r_fill;
        w_match     = 1'b0;
        if (r_tick) begin
            w_hist_next = {r_hist[PAT_W-2:0], x};
            if (r_fill != c_FILL_FULL) begin
                w_fill_next = r_fill + c_FILL_W'(1);
            end
            // Fill gating keeps reset zeros from matching an all-zero pattern.
            w_match = (w_fill_next == c_FILL_FULL) && (w_hist_next == PATTERN);
        end
    end

    // Non-overlapping mode discards history after a match; saturating match counter.
    always_comb begin
        w_fill_load = w_fill_next;
        if (w_match && (OVERLAP == 0)) begin
            w_fill_load = '0;
        end
        w_cnt_next = r_cnt;
        if (w_match && !(&r_cnt)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // Detector state; z reloads only at tick edges so it spans one full tick period.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_z    <= 1'b0;
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_hist <= w_hist_next;
            r_fill <= w_fill_load;
            r_cnt  <= w_cnt_next;
            r_sat  <= &w_cnt_next;
            if (r_tick) begin
                r_z <= w_match;
            end
        end
    end

    assign tick      = r_tick;
    assign z         = r_z;
    assign hist      = r_hist;
    assign fill      = r_fill;
    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_tick.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_tick
// Description : Scoreboard bench for seq_detect_tick. Three instances share
//               clk/clr/x: A = 1011 overlapping, B = 1011 non-overlapping,
//               C = 0000 overlapping with a 2-bit counter. x toggles on every
//               non-tick cycle so only tick-cycle values may reach hist.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_tick;

    localparam int c_DIV = 4;

    typedef struct packed {
        logic [3:0]      hist;
        logic [2:0]      z;
        logic [2:0][2:0] fill;
        logic [2:0][7:0] cnt;
        logic [2:0]      sat;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic x   = 1'b0;

    logic       tick_a, tick_b, tick_c;
    logic       z_a, z_b, z_c;
    logic [3:0] hist_a, hist_b, hist_c;
    logic [2:0] fill_a, fill_b, fill_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       sat_a, sat_b, sat_c;

    logic [2:0]      act_z, act_sat;
    logic [2:0][3:0] act_hist;
    logic [2:0][2:0] act_fill;
    logic [2:0][7:0] act_cnt;

    assign act_z    = {z_c, z_b, z_a};
    assign act_sat  = {sat_c, sat_b, sat_a};
    assign act_hist = {hist_c, hist_b, hist_a};
    assign act_fill = {fill_c, fill_b, fill_a};
    assign act_cnt  = {{6'b0, cnt_c}, cnt_b, cnt_a};

    exp_t exp_q[$];
    exp_t cur;
    int   k         = 0;
    int   n_vec     = 0;
    int   n_err     = 0;
    bit   mon_en    = 1'b0;
    bit   done      = 1'b0;
    bit   prev_tick = 1'b0;

    seq_detect_tick #(.PAT_W(4), .PATTERN(4'b1011), .DIV(c_DIV), .OVERLAP(1), .CNT_W(8)) u_a (
        .clk(clk), .clr(clr), .x(x), .tick(tick_a), .z(z_a), .hist(hist_a),
        .fill(fill_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    seq_detect_tick #(.PAT_W(4), .PATTERN(4'b1011), .DIV(c_DIV), .OVERLAP(0), .CNT_W(8)) u_b (
        .clk(clk), .clr(clr), .x(x), .tick(tick_b), .z(z_b), .hist(hist_b),
        .fill(fill_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    seq_detect_tick #(.PAT_W(4), .PATTERN(4'b0000), .DIV(c_DIV), .OVERLAP(1), .CNT_W(2)) u_c (
        .clk(clk), .clr(clr), .x(x), .tick(tick_c), .z(z_c), .hist(hist_c),
        .fill(fill_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_vec = n_vec + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s[%0d] at k=%0d t=%0t: got %0h, expected %0h", name, idx, k, $time, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] h,
                                input logic za, input logic [2:0] fa, input logic [7:0] ca,
                                input logic zb, input logic [2:0] fb, input logic [7:0] cb,
                                input logic zc, input logic [2:0] fc, input logic [7:0] cc,
                                input logic sc);
        exp_t e;
        e.hist    = h;
        e.z       = {zc, zb, za};
        e.fill[0] = fa;
        e.fill[1] = fb;
        e.fill[2] = fc;
        e.cnt[0]  = ca;
        e.cnt[1]  = cb;
        e.cnt[2]  = cc;
        e.sat     = {sc, 1'b0, 1'b0};
        return e;
    endfunction

    // Advance to the next tick cycle (by the bench's own cycle count), toggling x on the way.
    task automatic to_tick();
        do begin
            @(negedge clk);
            k = k + 1;
            if ((k % c_DIV) != 0) x = ~x;
        end while ((k % c_DIV) != 0);
    endtask

    task automatic step(input logic xv, input logic [3:0] h,
                        input logic za, input logic [2:0] fa, input logic [7:0] ca,
                        input logic zb, input logic [2:0] fb, input logic [7:0] cb,
                        input logic zc, input logic [2:0] fc, input logic [7:0] cc,
                        input logic sc);
        to_tick();
        x = xv;
        exp_q.push_back(mk(h, za, fa, ca, zb, fb, cb, zc, fc, cc, sc));
    endtask

    // Assert clr on a tick cycle: no shift may occur and the divider restarts.
    task automatic clr_on_tick();
        to_tick();
        clr = 1'b1;
        x   = ~x;
        exp_q.push_back('0);
        @(negedge clk);
        clr = 1'b0;
        k   = 1;
    endtask

    // Monitor: pops one expectation after every tick edge, checks tick timing and output hold every cycle.
    initial begin : monitor
        cur = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (prev_tick) begin
                    if (exp_q.size() == 0) begin
                        n_vec = n_vec + 1;
                        n_err = n_err + 1;
                        $display("FAIL scoreboard_underflow at k=%0d: got no expectation, expected one queued", k);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                chk("tick", 0, {31'b0, tick_a}, {31'b0, ((k % c_DIV) == 0)});
                chk("tick", 1, {31'b0, tick_b}, {31'b0, ((k % c_DIV) == 0)});
                chk("tick", 2, {31'b0, tick_c}, {31'b0, ((k % c_DIV) == 0)});
                for (int i = 0; i < 3; i++) begin
                    chk("hist", i, {28'b0, act_hist[i]}, {28'b0, cur.hist});
                    chk("z",    i, {31'b0, act_z[i]},    {31'b0, cur.z[i]});
                    chk("fill", i, {29'b0, act_fill[i]}, {29'b0, cur.fill[i]});
                    chk("cnt",  i, {24'b0, act_cnt[i]},  {24'b0, cur.cnt[i]});
                    chk("sat",  i, {31'b0, act_sat[i]},  {31'b0, cur.sat[i]});
                end
                prev_tick = tick_a;
                if (done) begin
                    chk("queue_left", 0, exp_q.size(), 0);
                    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                    $finish;
                end
            end
        end
    end

    // Stimulus: hand-computed expectations per tick for instances A, B, C.
    initial begin : driver
        clr = 1'b1;
        x   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr    = 1'b0;
        k      = 1;
        mon_en = 1'b1;

        //    x  hist     zA fA cA  zB fB cB  zC fC cC sC
        // Overlap / non-overlap: 1,0,1,1,0,1,1
        step(1, 4'b0001, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        step(0, 4'b0010, 0, 2, 0, 0, 2, 0, 0, 2, 0, 0);
        step(1, 4'b0101, 0, 3, 0, 0, 3, 0, 0, 3, 0, 0);
        step(1, 4'b1011, 1, 4, 1, 1, 0, 1, 0, 4, 0, 0);
        step(0, 4'b0110, 0, 4, 1, 0, 1, 1, 0, 4, 0, 0);
        step(1, 4'b1101, 0, 4, 1, 0, 2, 1, 0, 4, 0, 0);
        step(1, 4'b1011, 1, 4, 2, 0, 3, 1, 0, 4, 0, 0);

        clr_on_tick();

        // Fill gating and saturation: ten zero samples
        step(0, 4'b0000, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        step(0, 4'b0000, 0, 2, 0, 0, 2, 0, 0, 2, 0, 0);
        step(0, 4'b0000, 0, 3, 0, 0, 3, 0, 0, 3, 0, 0);
        step(0, 4'b0000, 0, 4, 0, 0, 4, 0, 1, 4, 1, 0);
        step(0, 4'b0000, 0, 4, 0, 0, 4, 0, 1, 4, 2, 0);
        step(0, 4'b0000, 0, 4, 0, 0, 4, 0, 1, 4, 3, 1);
        step(0, 4'b0000, 0, 4, 0, 0, 4, 0, 1, 4, 3, 1);
        step(0, 4'b0000, 0, 4, 0, 0, 4, 0, 1, 4, 3, 1);
        step(0, 4'b0000, 0, 4, 0, 0, 4, 0, 1, 4, 3, 1);
        step(0, 4'b0000, 0, 4, 0, 0, 4, 0, 1, 4, 3, 1);

        // Full history: non-overlapping instance restarts and re-matches
        step(1, 4'b0001, 0, 4, 0, 0, 4, 0, 0, 4, 3, 1);
        step(0, 4'b0010, 0, 4, 0, 0, 4, 0, 0, 4, 3, 1);
        step(1, 4'b0101, 0, 4, 0, 0, 4, 0, 0, 4, 3, 1);
        step(1, 4'b1011, 1, 4, 1, 1, 0, 1, 0, 4, 3, 1);
        step(1, 4'b0111, 0, 4, 1, 0, 1, 1, 0, 4, 3, 1);
        step(0, 4'b1110, 0, 4, 1, 0, 2, 1, 0, 4, 3, 1);
        step(1, 4'b1101, 0, 4, 1, 0, 3, 1, 0, 4, 3, 1);
        step(1, 4'b1011, 1, 4, 2, 1, 0, 2, 0, 4, 3, 1);

        @(negedge clk);
        k    = k + 1;
        x    = ~x;
        done = 1'b1;
    end

    // Time bound in case the monitor never reaches its summary.
    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no summary by t=%0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
